// File: rtl/framebuffer_command_sequencer_pkg.sv
// Shared state encodings, target indices and the commit-mask priority helper
// for the framebuffer command sequencer.
package framebuffer_command_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_MS_APPLY  = 3'd1;
  localparam state_t ST_MS_WAIT   = 3'd2;
  localparam state_t ST_CM_APPLY  = 3'd3;
  localparam state_t ST_CM_STREAM = 3'd4;
  localparam state_t ST_CM_WAIT   = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  typedef enum logic [1:0] {
    TARGET_COLOR   = 2'd0,
    TARGET_DEPTH   = 2'd1,
    TARGET_STENCIL = 2'd2
  } target_e;

  // Commits are issued lowest index first.
  function automatic logic [1:0] lowest_set_bit(input logic [3:0] mask);
    logic [1:0] idx;
    logic       found;
    idx   = 2'd0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fb_cmd_seq_axis_mux.sv
// Combinational N:1 AXI-stream mux with tready demux; only the selected
// target sees tready, and nothing passes while disabled.
module fb_cmd_seq_axis_mux #(
  parameter int unsigned NUMBER_OF_TARGETS = 3,
  parameter int unsigned STREAM_WIDTH      = 64,
  parameter int unsigned MASK_WIDTH        = 8,
  parameter int unsigned DEST_W            = 2
) (
  input  logic                                      enable,
  input  logic [DEST_W-1:0]                         sel,
  input  logic [NUMBER_OF_TARGETS-1:0]              s_tvalid,
  output logic [NUMBER_OF_TARGETS-1:0]              s_tready,
  input  logic [NUMBER_OF_TARGETS-1:0]              s_tlast,
  input  logic [NUMBER_OF_TARGETS*STREAM_WIDTH-1:0] s_tdata,
  input  logic [NUMBER_OF_TARGETS*MASK_WIDTH-1:0]   s_tstrb,
  output logic                                      m_tvalid,
  input  logic                                      m_tready,
  output logic                                      m_tlast,
  output logic [STREAM_WIDTH-1:0]                   m_tdata,
  output logic [MASK_WIDTH-1:0]                     m_tstrb
);

  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tstrb  = '0;
    s_tready = '0;
    for (int unsigned i = 0; i < NUMBER_OF_TARGETS; i++) begin
      if (DEST_W'(i) == sel) begin
        m_tvalid    = enable & s_tvalid[i];
        m_tlast     = s_tlast[i];
        m_tdata     = s_tdata[i*STREAM_WIDTH +: STREAM_WIDTH];
        m_tstrb     = s_tstrb[i*MASK_WIDTH +: MASK_WIDTH];
        s_tready[i] = enable & m_tready;
      end
    end
  end

endmodule

// File: rtl/framebuffer_command_sequencer.sv
// Sequences memset then per-target commit applies across framebuffer handlers
// and merges commit streams. Define FB_CMD_SEQ_STATS_EN for stall/command counters.
module framebuffer_command_sequencer
  import framebuffer_command_sequencer_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TARGETS   = 3,
  parameter int unsigned STREAM_WIDTH        = 64,
  parameter int unsigned MASK_WIDTH          = 8,
  parameter int unsigned FB_SIZE_IN_PIXEL_LG = 20,
  localparam int unsigned DEST_W = (NUMBER_OF_TARGETS > 1) ? $clog2(NUMBER_OF_TARGETS) : 1
) (
  input  logic                                          aclk,
  input  logic                                          reset,
  input  logic                                          s_cmd_valid,
  output logic                                          s_cmd_ready,
  input  logic [NUMBER_OF_TARGETS-1:0]                  s_cmd_memset,
  input  logic [NUMBER_OF_TARGETS-1:0]                  s_cmd_commit,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0]                s_cmd_size,
  output logic                                          busy,
  output logic [NUMBER_OF_TARGETS-1:0]                  fb_apply,
  input  logic [NUMBER_OF_TARGETS-1:0]                  fb_applied,
  output logic                                          fb_cmdMemset,
  output logic                                          fb_cmdCommit,
  output logic [FB_SIZE_IN_PIXEL_LG-1:0]                fb_cmdSize,
  input  logic [NUMBER_OF_TARGETS-1:0]                  s_axis_tvalid,
  output logic [NUMBER_OF_TARGETS-1:0]                  s_axis_tready,
  input  logic [NUMBER_OF_TARGETS-1:0]                  s_axis_tlast,
  input  logic [NUMBER_OF_TARGETS*STREAM_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUMBER_OF_TARGETS*MASK_WIDTH-1:0]       s_axis_tstrb,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic                                          m_axis_tlast,
  output logic [STREAM_WIDTH-1:0]                       m_axis_tdata,
  output logic [MASK_WIDTH-1:0]                         m_axis_tstrb,
  output logic [DEST_W-1:0]                             m_axis_tdest
`ifdef FB_CMD_SEQ_STATS_EN
  ,
  output logic [31:0]                                   stat_stall_cycles,
  output logic [15:0]                                   stat_commands
`endif
);

  state_t                         state;
  logic [NUMBER_OF_TARGETS-1:0]   ms_mask;
  logic [NUMBER_OF_TARGETS-1:0]   cm_mask;
  logic [NUMBER_OF_TARGETS-1:0]   seen_low;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] size_q;
  logic [DEST_W-1:0]              sel;
  logic [1:0]                     next_idx;
  logic [NUMBER_OF_TARGETS-1:0]   next_onehot;
  logic                           ms_ack;
  logic                           ms_idle;
  logic                           accept;
  logic                           beat_last;

  assign s_cmd_ready  = (state == ST_IDLE) && !reset;
  assign accept       = (state == ST_IDLE) && s_cmd_valid;
  assign fb_cmdSize   = size_q;
  assign m_axis_tdest = sel;
  assign next_idx     = lowest_set_bit(4'(cm_mask));
  assign beat_last    = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Include the current cycle so a target already low this cycle counts as acknowledged.
  assign ms_ack  = &(seen_low | ~fb_applied | ~ms_mask);
  assign ms_idle = &(fb_applied | ~ms_mask);

  always_comb begin
    next_onehot = '0;
    for (int unsigned i = 0; i < NUMBER_OF_TARGETS; i++) begin
      next_onehot[i] = (2'(i) == next_idx);
    end
  end

  always_comb begin
    fb_apply     = '0;
    fb_cmdMemset = 1'b0;
    fb_cmdCommit = 1'b0;
    case (state)
      ST_MS_APPLY: begin
        fb_apply     = ms_mask;
        fb_cmdMemset = 1'b1;
      end
      ST_CM_APPLY: begin
        fb_apply     = next_onehot;
        fb_cmdCommit = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      sel      <= '0;
      ms_mask  <= '0;
      cm_mask  <= '0;
      seen_low <= '0;
      size_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_cmd_valid) begin
            ms_mask  <= s_cmd_memset;
            cm_mask  <= s_cmd_commit;
            size_q   <= s_cmd_size;
            seen_low <= '0;
            busy     <= 1'b1;
            if (s_cmd_memset != '0)      state <= ST_MS_APPLY;
            else if (s_cmd_commit != '0) state <= ST_CM_APPLY;
            else                         state <= ST_DONE;
          end
        end
        ST_MS_APPLY: begin
          seen_low <= seen_low | ~fb_applied;
          if (ms_ack) state <= ST_MS_WAIT;
        end
        ST_MS_WAIT: begin
          if (ms_idle) state <= (cm_mask != '0) ? ST_CM_APPLY : ST_DONE;
        end
        ST_CM_APPLY: begin
          sel <= DEST_W'(next_idx);
          if (!fb_applied[next_idx]) state <= ST_CM_STREAM;
        end
        ST_CM_STREAM: begin
          if (beat_last) begin
            cm_mask[sel] <= 1'b0;
            state        <= ST_CM_WAIT;
          end
        end
        ST_CM_WAIT: begin
          if (fb_applied[sel]) state <= (cm_mask != '0) ? ST_CM_APPLY : ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fb_cmd_seq_axis_mux #(
    .NUMBER_OF_TARGETS(NUMBER_OF_TARGETS),
    .STREAM_WIDTH     (STREAM_WIDTH),
    .MASK_WIDTH       (MASK_WIDTH),
    .DEST_W           (DEST_W)
  ) u_mux (
    .enable  (state == ST_CM_STREAM),
    .sel     (sel),
    .s_tvalid(s_axis_tvalid),
    .s_tready(s_axis_tready),
    .s_tlast (s_axis_tlast),
    .s_tdata (s_axis_tdata),
    .s_tstrb (s_axis_tstrb),
    .m_tvalid(m_axis_tvalid),
    .m_tready(m_axis_tready),
    .m_tlast (m_axis_tlast),
    .m_tdata (m_axis_tdata),
    .m_tstrb (m_axis_tstrb)
  );

`ifdef FB_CMD_SEQ_STATS_EN
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      stat_stall_cycles <= '0;
      stat_commands     <= '0;
    end else begin
      if ((state == ST_CM_STREAM) && m_axis_tvalid && !m_axis_tready && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (accept)
        stat_commands <= stat_commands + 16'd1;
    end
  end
`endif

endmodule
